// File: rtl/return_address_stack_pkg.sv
// Shared sizing and checkpoint types for the speculative return address stack.
package return_address_stack_pkg;

    localparam int RAS_DEPTH = 8;
    localparam int PTR_W     = $clog2(RAS_DEPTH);
    localparam int CNT_W     = $clog2(RAS_DEPTH + 1);
    localparam int CKPT_W    = PTR_W + CNT_W;

    typedef struct packed {
        logic [PTR_W-1:0] tos;
        logic [CNT_W-1:0] count;
    } ras_checkpoint_t;

    // Fetch carries this alongside each predicted branch so execute can rewind the RAS.
    typedef struct packed {
        logic [31:0]     pc;
        logic            taken;
        ras_checkpoint_t ras_ckpt;
    } branch_metadata_t;

endpackage

// File: rtl/return_address_stack_if.sv
// Fetch/execute side of the return address stack: call/return hints, prediction, repair.
interface return_address_stack_if;
    import return_address_stack_pkg::*;

    logic            push;
    logic [31:0]     push_addr;
    logic            pop;
    logic [31:0]     pop_addr;
    logic            valid;
    ras_checkpoint_t ckpt;
    logic            repair_en;
    ras_checkpoint_t repair_ckpt;

    modport master (
        output push, push_addr, pop, repair_en, repair_ckpt,
        input  pop_addr, valid, ckpt
    );

    modport slave (
        input  push, push_addr, pop, repair_en, repair_ckpt,
        output pop_addr, valid, ckpt
    );

endinterface

// File: rtl/return_address_stack.sv
// Speculative return address stack: circular storage, saturating occupancy,
// checkpoint out to fetch and pointer-only restore from execute.
module return_address_stack
    import return_address_stack_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    return_address_stack_if.slave  bus
);

    logic [31:0]      stack_q [RAS_DEPTH];
    logic [31:0]      stack_d [RAS_DEPTH];
    logic [PTR_W-1:0] tos_q, tos_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] tos_inc;
    logic             not_empty;

    assign tos_inc   = tos_q + PTR_W'(1);
    assign not_empty = (count_q != '0);

    assign bus.pop_addr   = stack_q[tos_q];
    assign bus.valid      = not_empty;
    assign bus.ckpt.tos   = tos_q;
    assign bus.ckpt.count = count_q;

    always_comb begin
        stack_d = stack_q;
        tos_d   = tos_q;
        count_d = count_q;
        if (bus.repair_en) begin
            // Only pointers rewind; entries clobbered on the wrong path stay clobbered.
            tos_d   = bus.repair_ckpt.tos;
            count_d = bus.repair_ckpt.count;
        end else if (bus.push && bus.pop && not_empty) begin
            stack_d[tos_q] = bus.push_addr;
        end else if (bus.push) begin
            tos_d          = tos_inc;
            stack_d[tos_inc] = bus.push_addr;
            if (count_q != CNT_W'(RAS_DEPTH)) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (bus.pop && not_empty) begin
            tos_d   = tos_q - PTR_W'(1);
            count_d = count_q - CNT_W'(1);
        end
    end

    // Storage is reset too so pop_addr never presents X to fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
            tos_q   <= '0;
            count_q <= '0;
        end else begin
            stack_q <= stack_d;
            tos_q   <= tos_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_return_address_stack.sv
// Directed plus randomized checks of the return address stack against a ring-buffer model.
module tb_return_address_stack;
    import return_address_stack_pkg::*;

    logic clk;
    logic rst;

    return_address_stack_if ras_if ();

    return_address_stack dut (
        .clk (clk),
        .rst (rst),
        .bus (ras_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec;
    int          n_err;
    int          m_tos;
    int          m_cnt;
    logic [31:0] m_mem [RAS_DEPTH];
    ras_checkpoint_t hist [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ras_checkpoint_t m_ckpt();
        ras_checkpoint_t r;
        r.tos   = PTR_W'(m_tos);
        r.count = CNT_W'(m_cnt);
        return r;
    endfunction

    task automatic model_reset();
        m_tos = 0;
        m_cnt = 0;
        for (int i = 0; i < RAS_DEPTH; i++) m_mem[i] = '0;
    endtask

    task automatic model_update(input logic p, input logic [31:0] a, input logic q,
                                input logic r, input ras_checkpoint_t rc);
        if (r) begin
            m_tos = int'(rc.tos);
            m_cnt = int'(rc.count);
        end else if (p && q && m_cnt > 0) begin
            m_mem[m_tos] = a;
        end else if (p) begin
            m_tos = (m_tos + 1) % RAS_DEPTH;
            m_mem[m_tos] = a;
            if (m_cnt < RAS_DEPTH) m_cnt++;
        end else if (q && m_cnt > 0) begin
            m_tos = (m_tos + RAS_DEPTH - 1) % RAS_DEPTH;
            m_cnt--;
        end
    endtask

    task automatic check_all(input string tag);
        logic [CKPT_W-1:0] obs_ck;
        logic [CKPT_W-1:0] exp_ck;
        obs_ck = ras_if.ckpt;
        exp_ck = m_ckpt();
        chk({tag, ".pop_addr"}, ras_if.pop_addr, m_mem[m_tos]);
        chk({tag, ".valid"}, 32'(ras_if.valid), 32'(m_cnt != 0));
        chk({tag, ".ckpt"}, 32'(obs_ck), 32'(exp_ck));
    endtask

    task automatic step(input string tag, input logic p, input logic [31:0] a, input logic q,
                        input logic r, input ras_checkpoint_t rc);
        @(negedge clk);
        ras_if.push        = p;
        ras_if.push_addr   = a;
        ras_if.pop         = q;
        ras_if.repair_en   = r;
        ras_if.repair_ckpt = rc;
        @(posedge clk);
        model_update(p, a, q, r, rc);
        #1;
        ras_if.push      = 1'b0;
        ras_if.pop       = 1'b0;
        ras_if.repair_en = 1'b0;
        check_all(tag);
    endtask

    task automatic push_op(input string tag, input logic [31:0] a);
        step(tag, 1'b1, a, 1'b0, 1'b0, '0);
    endtask

    task automatic pop_op(input string tag);
        step(tag, 1'b0, '0, 1'b1, 1'b0, '0);
    endtask

    initial begin
        ras_checkpoint_t saved;
        logic [31:0]     ra;
        n_vec = 0;
        n_err = 0;
        ras_if.push        = 1'b0;
        ras_if.push_addr   = '0;
        ras_if.pop         = 1'b0;
        ras_if.repair_en   = 1'b0;
        ras_if.repair_ckpt = '0;
        rst = 1'b1;
        model_reset();

        // Reset asserted before any clock edge.
        #1 rst = 1'b0;
        #2;
        chk("rst.valid", 32'(ras_if.valid), 32'd0);
        chk("rst.pop_addr", ras_if.pop_addr, 32'd0);
        chk("rst.ckpt", 32'(ras_if.ckpt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step("idle", 1'b0, '0, 1'b0, 1'b0, '0);

        // LIFO order and underflow.
        push_op("lifo.push1", 32'h100);
        push_op("lifo.push2", 32'h200);
        push_op("lifo.push3", 32'h300);
        chk("lifo.top", ras_if.pop_addr, 32'h300);
        chk("lifo.count3", 32'(ras_if.ckpt.count), 32'd3);
        pop_op("lifo.pop1");
        chk("lifo.after_pop1", ras_if.pop_addr, 32'h200);
        pop_op("lifo.pop2");
        chk("lifo.after_pop2", ras_if.pop_addr, 32'h100);
        pop_op("lifo.pop3");
        chk("lifo.empty", 32'(ras_if.valid), 32'd0);
        pop_op("lifo.underflow");
        chk("lifo.underflow_cnt", 32'(ras_if.ckpt.count), 32'd0);
        chk("lifo.underflow_tos", 32'(ras_if.ckpt.tos), 32'd0);

        // Overflow: nine pushes into eight entries.
        for (int i = 1; i <= 9; i++) push_op("ovf.push", 32'(i * 16));
        chk("ovf.count", 32'(ras_if.ckpt.count), 32'd8);
        chk("ovf.top", ras_if.pop_addr, 32'h90);
        for (int i = 9; i >= 2; i--) begin
            chk("ovf.pop_val", ras_if.pop_addr, 32'(i * 16));
            pop_op("ovf.pop");
        end
        chk("ovf.empty", 32'(ras_if.valid), 32'd0);

        // Simultaneous push and pop.
        push_op("pp.push", 32'h200);
        step("pp.both", 1'b1, 32'h400, 1'b1, 1'b0, '0);
        chk("pp.replace", ras_if.pop_addr, 32'h400);
        chk("pp.count", 32'(ras_if.ckpt.count), 32'd1);
        pop_op("pp.drain");
        step("pp.both_empty", 1'b1, 32'h400, 1'b1, 1'b0, '0);
        chk("pp.empty_count", 32'(ras_if.ckpt.count), 32'd1);
        chk("pp.empty_top", ras_if.pop_addr, 32'h400);
        pop_op("pp.drain2");

        // Repair rewinds pointers; push in the same cycle is ignored.
        push_op("rep.push100", 32'h100);
        saved = m_ckpt();
        push_op("rep.push200", 32'h200);
        push_op("rep.push300", 32'h300);
        pop_op("rep.pop");
        step("rep.restore", 1'b1, 32'h999, 1'b0, 1'b1, saved);
        chk("rep.ckpt", 32'(ras_if.ckpt), 32'(saved));
        chk("rep.top", ras_if.pop_addr, 32'h100);

        // Randomized traffic with occasional repairs to earlier checkpoints.
        hist.delete();
        for (int i = 0; i < 400; i++) begin
            logic p, q, r;
            ras_checkpoint_t rc;
            p  = ($urandom_range(0, 99) < 45);
            q  = ($urandom_range(0, 99) < 40);
            r  = ($urandom_range(0, 15) == 0) && (hist.size() > 0);
            rc = r ? hist[$urandom_range(0, hist.size() - 1)] : '0;
            ra = $urandom();
            hist.push_back(m_ckpt());
            if (hist.size() > 16) void'(hist.pop_front());
            step("rand", p, ra, q, r, rc);
        end

        // Reset in the middle of activity, between clock edges.
        for (int i = 0; i < 5; i++) push_op("mid.push", 32'hA00 + 32'(i));
        #2 rst = 1'b0;
        #1;
        chk("mid.valid", 32'(ras_if.valid), 32'd0);
        chk("mid.pop_addr", ras_if.pop_addr, 32'd0);
        chk("mid.ckpt", 32'(ras_if.ckpt), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        push_op("mid.first_push", 32'hABC);
        chk("mid.first_tos", 32'(ras_if.ckpt.tos), 32'd1);
        chk("mid.first_top", ras_if.pop_addr, 32'hABC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
